// File: rtl/branch_cond_unit.sv
// Branch condition unit: flag register, condition decode and a
// one-entry valid/ready decision register with a taken counter.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   flags_in, flags_we       ALU flag update (Z,C,S,O = bits 0..3)
//   req_valid, req_ready     evaluation request handshake
//   opcode, condicao         1=jtrue/0=jfalse, condition select
//   dec_valid, dec_ready     decision handshake
//   saida_mux                taken decision (0 when no decision)
//   flags_q                  registered flags
//   taken_count              saturating count of consumed taken
module branch_cond_unit #(
  parameter int FLAG_W = 4,
  parameter int CNT_W  = 16,
  parameter int FWD    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              flags_we,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              opcode,
  input  logic [3:0]        condicao,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic              saida_mux,
  output logic [FLAG_W-1:0] flags_q,
  output logic [CNT_W-1:0]  taken_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;

  logic [FLAG_W-1:0] ev_flags;
  logic [6:0]        fx;
  logic              listed;
  logic              c;
  logic              result;
  logic              accept;
  logic              consume;
  logic              cnt_max;

  assign dec_valid = (state == FULL);
  assign req_ready = !dec_valid || dec_ready;
  assign accept    = req_valid && req_ready;
  assign consume   = dec_valid && dec_ready;
  assign cnt_max   = &taken_count;

  // Forwarding lets a flag write in the accept cycle steer the branch.
  assign ev_flags = ((FWD != 0) && flags_we) ? flags_in : flags_q;

  // Zero-extend to 7 bits so the extension codes read 0 above FLAG_W.
  always_comb begin
    fx = '0;
    for (int i = 0; i < FLAG_W; i++) begin
      fx[i] = ev_flags[i];
    end
  end

  always_comb begin
    listed = 1'b1;
    c      = 1'b0;
    unique case (condicao)
      4'b0100: c = fx[2];
      4'b0101: c = fx[0];
      4'b0110: c = fx[1];
      4'b0111: c = fx[0] | fx[2];
      4'b0000: c = !fx[0];
      4'b0011: c = fx[3];
      4'b0001: c = 1'b1;
      4'b1100: c = fx[4];
      4'b1101: c = fx[5];
      4'b1110: c = fx[6];
      default: listed = 1'b0;
    endcase
  end

  // Unlisted codes never branch, whatever the opcode.
  assign result = listed && (opcode ? c : !c);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      saida_mux   <= 1'b0;
      flags_q     <= '0;
      taken_count <= '0;
    end else begin
      if (flags_we) begin
        flags_q <= flags_in;
      end
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state     <= FULL;
            saida_mux <= result;
          end
        end
        FULL: begin
          // Accept while full implies consume: replace, no bubble.
          if (accept) begin
            saida_mux <= result;
          end else if (consume) begin
            state     <= EMPTY;
            saida_mux <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          saida_mux <= 1'b0;
        end
      endcase
      if (consume && saida_mux && !cnt_max) begin
        taken_count <= taken_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: four instances
// (default, FWD=0, CNT_W=2, FLAG_W=7) share one stimulus.
module tb_branch_cond_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] fl;
  logic       flags_we;
  logic       req_valid;
  logic       opcode;
  logic [3:0] condicao;
  logic       dec_ready;

  logic        rr0, rr1, rr2, rr3;
  logic        dv0, dv1, dv2, dv3;
  logic        sm0, sm1, sm2, sm3;
  logic [3:0]  fq0, fq1, fq2;
  logic [6:0]  fq3;
  logic [15:0] tc0, tc1, tc3;
  logic [1:0]  tc2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_cond_unit u0 (
    .clk(clk), .reset(reset), .flags_in(fl[3:0]),
    .flags_we(flags_we), .req_valid(req_valid),
    .req_ready(rr0), .opcode(opcode), .condicao(condicao),
    .dec_valid(dv0), .dec_ready(dec_ready), .saida_mux(sm0),
    .flags_q(fq0), .taken_count(tc0));

  branch_cond_unit #(.FWD(0)) u1 (
    .clk(clk), .reset(reset), .flags_in(fl[3:0]),
    .flags_we(flags_we), .req_valid(req_valid),
    .req_ready(rr1), .opcode(opcode), .condicao(condicao),
    .dec_valid(dv1), .dec_ready(dec_ready), .saida_mux(sm1),
    .flags_q(fq1), .taken_count(tc1));

  branch_cond_unit #(.CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .flags_in(fl[3:0]),
    .flags_we(flags_we), .req_valid(req_valid),
    .req_ready(rr2), .opcode(opcode), .condicao(condicao),
    .dec_valid(dv2), .dec_ready(dec_ready), .saida_mux(sm2),
    .flags_q(fq2), .taken_count(tc2));

  branch_cond_unit #(.FLAG_W(7)) u3 (
    .clk(clk), .reset(reset), .flags_in(fl),
    .flags_we(flags_we), .req_valid(req_valid),
    .req_ready(rr3), .opcode(opcode), .condicao(condicao),
    .dec_valid(dv3), .dec_ready(dec_ready), .saida_mux(sm3),
    .flags_q(fq3), .taken_count(tc3));

  typedef struct {
    logic [6:0] fl;
    logic       op;
    logic [3:0] cd;
    logic       e4;
    logic       e7;
  } vec_t;

  vec_t v[24];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    flags_we  = 1'b0;
    req_valid = 1'b0;
    opcode    = 1'b0;
    condicao  = 4'b0000;
    dec_ready = 1'b1;
    fl        = '0;
  endtask

  int unsigned base;
  logic [1:0] cexp[5];

  initial begin
    v[0]  = '{7'b0000001, 1'b1, 4'b0101, 1'b1, 1'b1};
    v[1]  = '{7'b0000001, 1'b0, 4'b0101, 1'b0, 1'b0};
    v[2]  = '{7'b0000100, 1'b1, 4'b0100, 1'b1, 1'b1};
    v[3]  = '{7'b0000000, 1'b1, 4'b0100, 1'b0, 1'b0};
    v[4]  = '{7'b0000010, 1'b1, 4'b0110, 1'b1, 1'b1};
    v[5]  = '{7'b0000100, 1'b1, 4'b0111, 1'b1, 1'b1};
    v[6]  = '{7'b0000000, 1'b1, 4'b0111, 1'b0, 1'b0};
    v[7]  = '{7'b0000000, 1'b1, 4'b0000, 1'b1, 1'b1};
    v[8]  = '{7'b0000001, 1'b1, 4'b0000, 1'b0, 1'b0};
    v[9]  = '{7'b0001000, 1'b1, 4'b0011, 1'b1, 1'b1};
    v[10] = '{7'b0000000, 1'b0, 4'b0011, 1'b1, 1'b1};
    v[11] = '{7'b0001111, 1'b1, 4'b1111, 1'b0, 1'b0};
    v[12] = '{7'b0001111, 1'b0, 4'b1111, 1'b0, 1'b0};
    v[13] = '{7'b0001111, 1'b1, 4'b0010, 1'b0, 1'b0};
    v[14] = '{7'b0000000, 1'b0, 4'b0010, 1'b0, 1'b0};
    v[15] = '{7'b0000000, 1'b1, 4'b0001, 1'b1, 1'b1};
    v[16] = '{7'b0000000, 1'b0, 4'b0001, 1'b0, 1'b0};
    v[17] = '{7'b0001111, 1'b1, 4'b1100, 1'b0, 1'b0};
    v[18] = '{7'b0001111, 1'b0, 4'b1101, 1'b1, 1'b1};
    v[19] = '{7'b0000000, 1'b1, 4'b1001, 1'b0, 1'b0};
    v[20] = '{7'b0110000, 1'b1, 4'b1100, 1'b0, 1'b1};
    v[21] = '{7'b1000000, 1'b1, 4'b1110, 1'b0, 1'b1};
    v[22] = '{7'b1000000, 1'b0, 4'b1110, 1'b1, 1'b0};
    v[23] = '{7'b0000000, 1'b0, 4'b1001, 1'b0, 1'b0};

    idle();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_dv", 32'(dv0), 0);
    chk("rst_sm", 32'(sm0), 0);
    chk("rst_fq", 32'(fq0), 0);
    chk("rst_tc", 32'(tc0), 0);
    reset     = 1'b0;
    dec_ready = 1'b0;
    #1;
    chk("rst_rr", 32'(rr0), 1);
    tick();
    dec_ready = 1'b1;

    // Table: load flags, evaluate, check, consume.
    for (int i = 0; i < 24; i++) begin
      fl       = v[i].fl;
      flags_we = 1'b1;
      tick();
      flags_we  = 1'b0;
      req_valid = 1'b1;
      opcode    = v[i].op;
      condicao  = v[i].cd;
      #1;
      chk($sformatf("v%0d_rr", i), 32'(rr0), 1);
      tick();
      req_valid = 1'b0;
      chk($sformatf("v%0d_dv", i), 32'(dv0), 1);
      chk($sformatf("v%0d_sm", i), 32'(sm0), 32'(v[i].e4));
      chk($sformatf("v%0d_sm_nf", i), 32'(sm1), 32'(v[i].e4));
      chk($sformatf("v%0d_sm7", i), 32'(sm3), 32'(v[i].e7));
      chk($sformatf("v%0d_fq", i), 32'(fq0), 32'(v[i].fl[3:0]));
      chk($sformatf("v%0d_fq7", i), 32'(fq3), 32'(v[i].fl));
      tick();
      chk($sformatf("v%0d_dv_off", i), 32'(dv0), 0);
      chk($sformatf("v%0d_sm_off", i), 32'(sm0), 0);
    end

    // Same-cycle flag write: forwarded vs registered flags.
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("fwd_fq0", 32'(fq0), 0);
    fl        = 7'b0000100;
    flags_we  = 1'b1;
    req_valid = 1'b1;
    opcode    = 1'b1;
    condicao  = 4'b0100;
    tick();
    idle();
    chk("fwd1_sm", 32'(sm0), 1);
    chk("fwd0_sm", 32'(sm1), 0);
    chk("fwd0_fq", 32'(fq1), 4'b0100);
    chk("fwd1_fq", 32'(fq0), 4'b0100);
    tick();

    // Backpressure hold, then back-to-back accepts.
    req_valid = 1'b1;
    opcode    = 1'b1;
    condicao  = 4'b0001;
    dec_ready = 1'b0;
    tick();
    chk("bp_dv", 32'(dv0), 1);
    chk("bp_sm", 32'(sm0), 1);
    opcode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_rr%0d", k), 32'(rr0), 0);
      tick();
      chk($sformatf("bp_dv%0d", k), 32'(dv0), 1);
      chk($sformatf("bp_sm%0d", k), 32'(sm0), 1);
    end
    dec_ready = 1'b1;
    #1;
    chk("bb_rr", 32'(rr0), 1);
    tick();
    chk("bb_dv1", 32'(dv0), 1);
    chk("bb_sm1", 32'(sm0), 0);
    opcode = 1'b1;
    tick();
    chk("bb_dv2", 32'(dv0), 1);
    chk("bb_sm2", 32'(sm0), 1);
    req_valid = 1'b0;
    tick();
    chk("bb_dv3", 32'(dv0), 0);
    chk("bb_sm3", 32'(sm0), 0);

    // Saturating counter with CNT_W=2.
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("cnt_start", 32'(tc2), 0);
    base = 32'(tc0);
    cexp[0] = 2'd1;
    cexp[1] = 2'd2;
    cexp[2] = 2'd3;
    cexp[3] = 2'd3;
    cexp[4] = 2'd3;
    req_valid = 1'b1;
    opcode    = 1'b1;
    condicao  = 4'b0001;
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) req_valid = 1'b0;
      tick();
      chk($sformatf("cnt%0d", k), 32'(tc2), 32'(cexp[k]));
    end
    chk("cnt16", 32'(tc0), base + 5);

    // Reset with a pending decision.
    fl        = 7'b0001111;
    flags_we  = 1'b1;
    req_valid = 1'b1;
    opcode    = 1'b1;
    condicao  = 4'b0001;
    dec_ready = 1'b0;
    tick();
    chk("pr_dv", 32'(dv0), 1);
    reset     = 1'b1;
    dec_ready = 1'b1;
    tick();
    chk("pr_dv0", 32'(dv0), 0);
    chk("pr_sm0", 32'(sm0), 0);
    chk("pr_tc0", 32'(tc0), 0);
    chk("pr_tc2", 32'(tc2), 0);
    chk("pr_fq0", 32'(fq0), 0);
    reset     = 1'b0;
    req_valid = 1'b0;
    flags_we  = 1'b0;
    dec_ready = 1'b0;
    #1;
    chk("pr_rr", 32'(rr0), 1);
    tick();
    chk("pr_tc_after", 32'(tc0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- FLAG_W, 4, flag vector width; bits 0..3 fixed as Z, C, S, O; legal range 4..7.
- CNT_W, 16, taken-branch counter width.
- FWD, 1, 1 = same-cycle flag write forwarded into evaluation; 0 = registered flags only.

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- flags_in  in  FLAG_W  new ALU flags.
- flags_we  in  1  load flags_in into flag register.
- req_valid  in  1  branch evaluation request from UC.
- req_ready  out  1  request accepted when req_valid && req_ready.
- opcode  in  1  1 = jtrue, 0 = jfalse.
- condicao  in  4  condition select.
- dec_valid  out  1  decision available.
- dec_ready  in  1  consumer accepts decision.
- saida_mux  out  1  branch-taken decision, valid while dec_valid.
- flags_q  out  FLAG_W  registered flags.
- taken_count  out  CNT_W  saturating count of consumed taken decisions.

Function
REQ-003 The flag register SHALL load flags_in at each edge where flags_we=1, and otherwise hold its value.
REQ-004 Evaluation flags SHALL be flags_in when FWD=1 and flags_we=1 in the acceptance cycle; otherwise they SHALL be flags_q.
REQ-005 The raw condition c SHALL be:
- 0100 = S.
- 0101 = Z.
- 0110 = C.
- 0111 = Z|S.
- 0000 = !Z.
- 0011 = O.
- 0001 = 1 (always).
- 1000+k, for k = 4..6 = flags[k] if k < FLAG_W, else 0.
REQ-006 For the codes in REQ-005, the result SHALL be c when opcode=1 and !c when opcode=0.
REQ-007 For condicao=1111 and all other unlisted codes, the result SHALL be 0 regardless of opcode.
REQ-008 On acceptance, the result SHALL be captured into a one-entry output register, giving dec_valid=1 and saida_mux=result on the next cycle (latency 1).
REQ-009 req_ready SHALL equal !dec_valid || dec_ready, combinationally.
REQ-010 While dec_valid=1 && dec_ready=0, saida_mux SHALL hold stable and no request SHALL be accepted.
REQ-011 Simultaneous consume and accept SHALL replace the output entry with the new decision, keeping dec_valid=1 with no bubble.
REQ-012 Consume without accept SHALL clear dec_valid on the next edge.
REQ-013 The output state machine SHALL have two states with these transitions:
- EMPTY -> FULL on accept.
- FULL -> EMPTY on consume without accept.
- FULL -> FULL on hold, or on consume with accept.
REQ-014 taken_count SHALL increment by 1 on each consume with saida_mux=1, and SHALL saturate at 2^CNT_W-1.
REQ-015 A flag write and a request arriving in the same cycle with FWD=0 SHALL evaluate the old flags; the flag register SHALL still update.
REQ-016 saida_mux SHALL be 0 whenever dec_valid=0.

Reset
REQ-017 While reset=1 at an edge, the block SHALL set flags_q=0, dec_valid=0, saida_mux=0 and taken_count=0.
REQ-018 Reset SHALL override flags_we, accept and consume in the same cycle.
REQ-019 A pending decision SHALL be discarded on reset and not counted.
REQ-020 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Write flags 4'b0001, then request opcode=1 cond=0101 -> next cycle dec_valid=1, saida_mux=1; repeat with opcode=0 -> saida_mux=0.
- FWD=1: flags_q=0, same cycle flags_we=1 with flags_in=4'b0100 and request cond=0100 opcode=1 -> saida_mux=1; with FWD=0 -> saida_mux=0, flags_q=4'b0100.
- Hold dec_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and saida_mux stable; then dec_ready=1 -> back-to-back accepts with no bubble.
- cond=1111 and cond=0010, each with opcode 0 and 1 -> saida_mux=0 in all four cases; cond=0001 opcode=1 -> 1.
- CNT_W=2: five consumed taken decisions -> taken_count = 1, 2, 3, 3, 3.
- Assert reset while dec_valid=1 -> next cycle dec_valid=0, saida_mux=0, taken_count=0, flags_q=0.
